// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared port IDs, status/ctrl bit indices and drain FSM states for the VGA bridge
package vga_pkg;

  localparam logic [7:0] P_ADDR_LO_DEF = 8'd40;
  localparam logic [7:0] P_DATA_DEF    = 8'd41;
  localparam logic [7:0] P_ADDR_HI_DEF = 8'd42;
  localparam logic [7:0] P_CTRL_DEF    = 8'd43;
  localparam logic [7:0] P_STATUS_DEF  = 8'd51;

  localparam int ST_VBL    = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_FRM_LO = 4;
  localparam int ST_FRM_HI = 7;

  localparam int CTRL_AUTOINC = 0;
  localparam int CTRL_GATE    = 1;
  localparam int CTRL_CLR_OVF = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// rtl/vga_wr_fifo.sv - count-based synchronous write FIFO holding {address, data} entries
module vga_wr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_port_bridge.sv
// rtl/vga_port_bridge.sv - CPU port decode, write buffering and blank-gated drain into video memory
module vga_port_bridge
  import vga_pkg::*;
#(
  parameter int         ADDR_W     = 8,
  parameter int         DATA_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] P_ADDR_LO  = P_ADDR_LO_DEF,
  parameter logic [7:0] P_DATA     = P_DATA_DEF,
  parameter logic [7:0] P_ADDR_HI  = P_ADDR_HI_DEF,
  parameter logic [7:0] P_CTRL     = P_CTRL_DEF,
  parameter logic [7:0] P_STATUS   = P_STATUS_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        Port_ID,
  input  logic [7:0]        IN_DATA,
  input  logic              Write_Strobe,
  input  logic              Read_Strobe,
  output logic [7:0]        OUT_DATA,
  input  logic              VSync,
  input  logic              Blank,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_WE
);

  logic [ADDR_W-1:0]        addr_reg;
  logic [ADDR_W-1:0]        addr_loaded;
  logic                     ctrl_autoinc;
  logic                     ctrl_gate;
  logic                     overflow;
  logic [3:0]               frame_cnt;
  logic                     vsync_prev;
  drain_state_t             state;
  logic [ADDR_W+DATA_W-1:0] head;
  logic                     full;
  logic                     empty;
  logic                     lo_wr;
  logic                     ctrl_wr;
  logic                     push_req;
  logic                     push_ok;
  logic                     pop;
  logic [7:0]               status;

  assign lo_wr    = Write_Strobe && (Port_ID == P_ADDR_LO);
  assign ctrl_wr  = Write_Strobe && (Port_ID == P_CTRL);
  assign push_req = Write_Strobe && (Port_ID == P_DATA);
  assign pop      = !empty && (!ctrl_gate || Blank);
  assign push_ok  = push_req && (!full || pop);

  generate
    if (ADDR_W > 8) begin : g_wide_addr
      logic hi_wr;
      assign hi_wr = Write_Strobe && (Port_ID == P_ADDR_HI);
      always_comb begin
        addr_loaded = addr_reg;
        if (lo_wr) addr_loaded[7:0] = IN_DATA;
        if (hi_wr) addr_loaded[ADDR_W-1:8] = IN_DATA[ADDR_W-9:0];
      end
    end else begin : g_narrow_addr
      always_comb begin
        addr_loaded = addr_reg;
        if (lo_wr) addr_loaded = IN_DATA[ADDR_W-1:0];
      end
    end
  endgenerate

  vga_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (push_ok),
    .wr_data ({addr_reg, IN_DATA[DATA_W-1:0]}),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_reg     <= '0;
      ctrl_autoinc <= 1'b0;
      ctrl_gate    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (push_ok && ctrl_autoinc) begin
        addr_reg <= addr_reg + ADDR_W'(1);
      end else begin
        addr_reg <= addr_loaded;
      end
      if (ctrl_wr) begin
        ctrl_autoinc <= IN_DATA[CTRL_AUTOINC];
        ctrl_gate    <= IN_DATA[CTRL_GATE];
      end
      // A new drop on the clearing edge still wins so no overflow goes unreported.
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (ctrl_wr && IN_DATA[CTRL_CLR_OVF]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          MEM_WE <= 1'b0;
          if (pop) begin
            {MEM_ADDR, MEM_DATA} <= head;
            MEM_WE               <= 1'b1;
            state                <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (pop) begin
            {MEM_ADDR, MEM_DATA} <= head;
            MEM_WE               <= 1'b1;
          end else begin
            MEM_WE <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          MEM_WE <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vsync_prev <= 1'b0;
      frame_cnt  <= 4'd0;
    end else begin
      vsync_prev <= VSync;
      if (vsync_prev && !VSync) begin
        frame_cnt <= frame_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    status                      = 8'h00;
    status[ST_VBL]              = ~VSync;
    status[ST_FULL]             = full;
    status[ST_EMPTY]            = empty;
    status[ST_OVF]              = overflow;
    status[ST_FRM_HI:ST_FRM_LO] = frame_cnt;
    OUT_DATA = (Read_Strobe && (Port_ID == P_STATUS)) ? status : 8'h00;
  end

endmodule
